// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port round-robin arbiter and sequencer in front of a single-port data
//   memory with combinational read data. Port 0 is the core load/store path,
//   port 1 the debug/DMA loader. Each granted request takes three cycles
//   (IDLE -> ACCESS -> RESP). The address is range- and alignment-checked,
//   and the owner receives a one-cycle response.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   pN_valid/pN_ready              request handshake (N = 0, 1)
//   pN_we, pN_addr, pN_wdata       request: write flag, byte address, data
//   pN_rsp_valid                   one-cycle response pulse to the owner
//   rsp_rdata, rsp_err             shared response payload
//   mem_addr, mem_data_in,
//   mem_wr_en, mem_data_out        single-port memory interface
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | arbitrate; the winner sees ready and its request is latched
// ACCESS | latched request drives memory; write commits at the end edge
// RESP   | owner's rsp_valid pulses with captured rdata/err
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_rsp_valid,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_wr_en,
  input  logic [31:0] mem_data_out
);

  // End of the window, one past the last byte. It is held in 33 bits so a
  // window that reaches the top of the address space does not wrap to a
  // small value.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   owner;
  logic   we_q;
  logic   grant_0;
  logic   grant_1;
  logic   addr_err;

  // mem_addr holds the latched request address from the accept edge onward,
  // so the range check runs directly on it.
  assign addr_err = (mem_addr[1:0] != 2'b00) ||
                    (mem_addr < BASE_ADDR) ||
                    ({1'b0, mem_addr} >= END_ADDR);

  // On a tie, the port that was not granted last wins. Readies are held low
  // while reset is asserted, so every output reads 0 during reset.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (p0_valid && p1_valid) begin
        grant_0 = last_grant;
        grant_1 = ~last_grant;
      end else begin
        grant_0 = p0_valid;
        grant_1 = p1_valid;
      end
    end
  end

  assign p0_ready = grant_0;
  assign p1_ready = grant_1;

  // This is a decode of registered state. When reset asserts, the state
  // clears asynchronously, so the write enable falls at once and a pending
  // write is abandoned.
  assign mem_wr_en = (state == ACCESS) && we_q && !addr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      we_q         <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
    end else begin
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_0 || grant_1) begin
            owner       <= grant_1;
            last_grant  <= grant_1;
            we_q        <= grant_1 ? p1_we : p0_we;
            mem_addr    <= grant_1 ? p1_addr : p0_addr;
            mem_data_in <= grant_1 ? p1_wdata : p0_wdata;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_err      <= addr_err;
          rsp_rdata    <= (we_q || addr_err) ? 32'h0 : mem_data_out;
          p0_rsp_valid <= ~owner;
          p1_rsp_valid <= owner;
          state        <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
